// File: rtl/sipo_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sipo_deser_pkg
// Purpose : Shared definitions for the sipo_deser deserializer: default word
//           width and FSM state encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sipo_deser_pkg;

  // Default data word width
  localparam int DW_DEFAULT = 8;

  // FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module  : sipo_deser
// Purpose : Serial-in/parallel-out deserializer. Packs DW serial bits, LSB
//           first, into a word presented on a valid/ready output with a
//           single output register and a sticky overflow flag.
// Config  : define SIPO_DESER_PARITY_EN to expect one even-parity bit after
//           each word (adds S_PAR state and drives o_perr).
// Ports   : i_clk      - clock, rising edge
//           i_rst      - asynchronous active-high reset
//           i_bit      - serial data bit
//           i_bit_vld  - i_bit is sampled when high
//           i_clr      - synchronous flush of all state
//           i_rdy      - downstream ready
//           o_data     - assembled word
//           o_vld      - o_data holds an unconsumed word
//           o_perr     - parity error of o_data word (0 without parity)
//           o_ovf      - sticky: a completed word was dropped
//           o_cnt      - bits collected in the current word
// Revision: 1.0 - initial release
// ============================================================================
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  localparam int CW = $clog2(DW + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_bit,
  input  logic          i_bit_vld,
  input  logic          i_clr,
  input  logic          i_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_vld,
  output logic          o_perr,
  output logic          o_ovf,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  // Without parity the final data bit goes straight into the output
  // register, so the shift register only has to hold the first DW-1 bits.
`ifdef SIPO_DESER_PARITY_EN
  localparam int SRW = DW;
`else
  localparam int SRW = DW - 1;
`endif

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [SRW-1:0] shreg;
  logic [SRW-1:0] shreg_nxt;
  logic           done;
  logic [DW-1:0]  word;
`ifdef SIPO_DESER_PARITY_EN
  logic           perr_new;
`endif

  // Right shift so that, once full, the first accepted bit sits at bit 0.
  assign shreg_nxt = SRW'({i_bit, shreg} >> 1);

  // --------------------------------------------------------------------------
  // Word completion detect
  // --------------------------------------------------------------------------
  always_comb begin
    done = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    word     = shreg;
    perr_new = ^{shreg, i_bit};
    if (i_bit_vld && (state == S_PAR)) begin
      done = 1'b1;
    end
`else
    word = {i_bit, shreg};
    if (i_bit_vld && (state == S_SHIFT) && (cnt == LAST_BIT)) begin
      done = 1'b1;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM, bit counter and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (i_clr) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (i_bit_vld) begin
      case (state)
        S_IDLE: begin
          shreg <= shreg_nxt;
          cnt   <= CW'(1);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg <= shreg_nxt;
          if (cnt == LAST_BIT) begin
`ifdef SIPO_DESER_PARITY_EN
            cnt   <= CW'(DW);
            state <= S_PAR;
`else
            cnt   <= '0;
            state <= S_IDLE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef SIPO_DESER_PARITY_EN
        S_PAR: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
`endif
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register and overflow
  // A completing word is taken if the register is empty or being drained on
  // this same edge; otherwise it is dropped and the overflow flag latches.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
      o_vld  <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (i_clr) begin
      o_data <= '0;
      o_vld  <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (done) begin
      if (!o_vld || i_rdy) begin
        o_data <= word;
        o_vld  <= 1'b1;
      end else begin
        o_ovf  <= 1'b1;
      end
    end else if (o_vld && i_rdy) begin
      o_vld <= 1'b0;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  // Parity flag follows the word it belongs to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perr <= 1'b0;
    end else if (i_clr) begin
      o_perr <= 1'b0;
    end else if (done && (!o_vld || i_rdy)) begin
      o_perr <= perr_new;
    end
  end
`else
  assign o_perr = 1'b0;
`endif

  assign o_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module  : tb_sipo_deser
// Purpose : Self-checking bench for sipo_deser (DW=8). Expected words are
//           queued when driven and compared when the DUT hands them off.
//           Honours SIPO_DESER_PARITY_EN the same way as the design.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);
`ifdef SIPO_DESER_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_vld = 1'b0;
  logic          clr = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_vld;
  logic          o_perr;
  logic          o_ovf;
  logic [CW-1:0] o_cnt;

  int errors = 0;
  int checks = 0;
  int n_xfer = 0;
  logic [DW-1:0] exp_q[$];

  sipo_deser #(.DW(DW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_bit    (bit_in),
    .i_bit_vld(bit_vld),
    .i_clr    (clr),
    .i_rdy    (rdy),
    .o_data   (o_data),
    .o_vld    (o_vld),
    .o_perr   (o_perr),
    .o_ovf    (o_ovf),
    .o_cnt    (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake mid-cycle, then advance past the edge.
  task automatic step();
    logic [DW-1:0] w;
    @(negedge clk);
    if (o_vld && rdy) begin
      n_xfer++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_data", 32'(o_data), 32'(w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Serial bit i of word w (index DW is the even-parity bit).
  function automatic logic sbit(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[i];
    return ^w;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    bit_in  = b;
    bit_vld = 1'b1;
    step();
    bit_vld = 1'b0;
    bit_in  = 1'b0;
    repeat (gap) step();
  endtask

  // Send serial bits [first, first+n) of w, gaps 0..gmax after all but the last.
  task automatic send_bits(input logic [DW-1:0] w, input int first, input int n, input int gmax);
    for (int i = first; i < first + n; i++) begin
      send_bit(sbit(w, i), (i == first + n - 1 || gmax == 0) ? 0 : int'($urandom_range(gmax)));
    end
  endtask

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_vld",  32'(o_vld),  32'h0);
    check("rst_perr", 32'(o_perr), 32'h0);
    check("rst_ovf",  32'(o_ovf),  32'h0);
    check("rst_cnt",  32'(o_cnt),  32'h0);
    rst = 1'b0;
    step();

    // ---------------- 1: async reset mid-word
    rdy = 1'b0;
    send_bits(8'h77, 0, NB, 2);
    check("t1_pre_vld", 32'(o_vld), 32'h1);
    send_bits(8'h0F, 0, 3, 2);
    check("t1_pre_cnt", 32'(o_cnt), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("t1_async_cnt", 32'(o_cnt), 32'd0);
    check("t1_async_vld", 32'(o_vld), 32'd0);
    #1 rst = 1'b0;
    send_bits(8'hA5, 0, NB, 0);
    check("t1_vld",  32'(o_vld),  32'h1);
    check("t1_data", 32'(o_data), 32'hA5);
    check("t1_cnt",  32'(o_cnt),  32'd0);
    check("t1_perr", 32'(o_perr), 32'h0);
    exp_q.push_back(8'hA5);
    rdy = 1'b1;
    step();
    check("t1_drain_vld", 32'(o_vld), 32'h0);

    // ---------------- 2: random gaps, one pulse
    n_xfer = 0;
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 0, NB, 10);
    repeat (4) step();
    check("t2_pulses", 32'(n_xfer), 32'd1);
    check("t2_vld",    32'(o_vld),  32'h0);
    check("t2_ovf",    32'(o_ovf),  32'h0);

    // ---------------- 3: stall and overflow
    rdy = 1'b0;
    send_bits(8'h3C, 0, NB, 3);
    check("t3_first_data", 32'(o_data), 32'h3C);
    check("t3_first_ovf",  32'(o_ovf),  32'h0);
    send_bits(8'hFF, 0, NB, 3);
    check("t3_data", 32'(o_data), 32'h3C);
    check("t3_vld",  32'(o_vld),  32'h1);
    check("t3_ovf",  32'(o_ovf),  32'h1);
    exp_q.push_back(8'h3C);
    rdy = 1'b1;
    step();
    check("t3_drain_vld", 32'(o_vld), 32'h0);
    check("t3_ovf_sticky", 32'(o_ovf), 32'h1);

    // ---------------- 4: back-to-back transfer and completion
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr_ovf", 32'(o_ovf), 32'h0);
    rdy = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 0, NB, 2);
    check("t4_hold_data", 32'(o_data), 32'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h22, 0, NB - 1, 2);
    check("t4_hold_data2", 32'(o_data), 32'h11);
    rdy = 1'b1;
    send_bits(8'h22, NB - 1, 1, 0);
    check("t4_data", 32'(o_data), 32'h22);
    check("t4_vld",  32'(o_vld),  32'h1);
    check("t4_ovf",  32'(o_ovf),  32'h0);
    step();
    check("t4_drain_vld", 32'(o_vld), 32'h0);

    // ---------------- 5: clear with simultaneous bit
    rdy = 1'b0;
    send_bits(8'h81, 0, NB, 1);
    send_bits(8'h42, 0, NB, 1);
    check("t5_pre_ovf", 32'(o_ovf), 32'h1);
    send_bits(8'hFF, 0, 5, 1);
    check("t5_pre_cnt", 32'(o_cnt), 32'd5);
    clr     = 1'b1;
    bit_in  = 1'b1;
    bit_vld = 1'b1;
    step();
    clr     = 1'b0;
    bit_vld = 1'b0;
    check("t5_cnt",  32'(o_cnt),  32'd0);
    check("t5_vld",  32'(o_vld),  32'h0);
    check("t5_ovf",  32'(o_ovf),  32'h0);
    check("t5_data", 32'(o_data), 32'h0);
    send_bits(8'h0F, 0, NB, 1);
    check("t5_next_data", 32'(o_data), 32'h0F);
    exp_q.push_back(8'h0F);
    rdy = 1'b1;
    step();

`ifdef SIPO_DESER_PARITY_EN
    // ---------------- 6: parity
    rdy = 1'b0;
    send_bits(8'hA5, 0, DW, 2);
    check("t6_nopar_vld", 32'(o_vld), 32'h0);
    check("t6_nopar_cnt", 32'(o_cnt), 32'd8);
    send_bit(1'b0, 0);
    check("t6_good_vld",  32'(o_vld),  32'h1);
    check("t6_good_perr", 32'(o_perr), 32'h0);
    check("t6_good_data", 32'(o_data), 32'hA5);
    exp_q.push_back(8'hA5);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    send_bits(8'hA5, 0, DW, 2);
    send_bit(1'b1, 0);
    check("t6_bad_vld",  32'(o_vld),  32'h1);
    check("t6_bad_perr", 32'(o_perr), 32'h1);
    exp_q.push_back(8'hA5);
    rdy = 1'b1;
    step();
`endif

    repeat (2) step();
    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    check("final_vld", 32'(o_vld), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
